// File: rtl/display_scan_select.sv
// Registered N:1 word selector for the debug display path: manual select or
// timed auto-scan, with freeze and a one-cycle pulse whenever the channel changes.
module display_scan_select #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int DWELL    = 50_000_000,
  parameter int DWELL_W  = 26
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      freeze,
  output logic [WIDTH-1:0]          data_out,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      sel_changed
);

  // One extra bit so the bound is representable even when CHANNELS == 2**SEL_W.
  localparam logic [SEL_W:0]     CH_LIM   = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0]   LAST_CH  = SEL_W'(CHANNELS - 1);
  localparam logic [DWELL_W-1:0] LAST_CNT = DWELL_W'(DWELL - 1);

  logic [SEL_W-1:0]   r_cur_sel;
  logic [WIDTH-1:0]   r_data_out;
  logic [DWELL_W-1:0] r_cnt;
  logic               r_mode_q;
  logic               r_sel_changed;

  logic [SEL_W-1:0]   w_cur_sel_next;
  logic [WIDTH-1:0]   w_data_out_next;
  logic [DWELL_W-1:0] w_cnt_next;
  logic               w_mode_q_next;
  logic               w_sel_changed_next;
  logic [WIDTH-1:0]   w_sel_word;

  always_comb begin
    w_sel_word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (r_cur_sel == SEL_W'(k)) w_sel_word = data_in[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    w_cur_sel_next     = r_cur_sel;
    w_data_out_next    = r_data_out;
    w_cnt_next         = r_cnt;
    w_mode_q_next      = r_mode_q;
    w_sel_changed_next = 1'b0;
    if (!freeze) begin
      w_data_out_next = w_sel_word;
      if (mode != r_mode_q) begin
        // Mode edge: restart the dwell timer, keep the channel for this cycle.
        w_cnt_next    = '0;
        w_mode_q_next = mode;
      end else if (!mode) begin
        if ({1'b0, sel_in} < CH_LIM) w_cur_sel_next = sel_in;
        w_cnt_next = '0;
      end else if (r_cnt == LAST_CNT) begin
        w_cnt_next     = '0;
        w_cur_sel_next = (r_cur_sel == LAST_CH) ? '0 : r_cur_sel + SEL_W'(1);
      end else begin
        w_cnt_next = r_cnt + DWELL_W'(1);
      end
      w_sel_changed_next = (w_cur_sel_next != r_cur_sel);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_sel     <= '0;
      r_data_out    <= '0;
      r_cnt         <= '0;
      r_mode_q      <= 1'b0;
      r_sel_changed <= 1'b0;
    end else begin
      r_cur_sel     <= w_cur_sel_next;
      r_data_out    <= w_data_out_next;
      r_cnt         <= w_cnt_next;
      r_mode_q      <= w_mode_q_next;
      r_sel_changed <= w_sel_changed_next;
    end
  end

  assign data_out    = r_data_out;
  assign cur_sel     = r_cur_sel;
  assign sel_changed = r_sel_changed;

endmodule
